// File: rtl/fc_pkg.sv
// Shared definitions for the LeNet fully-connected layer controllers:
// one-hot FSM encoding and the default layer dimensions.
package fc_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_RUN   = 4'b0010;
  localparam logic [ST_W-1:0] ST_DRAIN = 4'b0100;
  localparam logic [ST_W-1:0] ST_DONE  = 4'b1000;

  typedef struct packed {
    logic [15:0] in_len;
    logic [15:0] out_len;
  } fc_dims_t;

  localparam fc_dims_t FC1_DIMS = '{in_len: 16'd400, out_len: 16'd120};
  localparam fc_dims_t FC2_DIMS = '{in_len: 16'd120, out_len: 16'd84};
  localparam fc_dims_t FC3_DIMS = '{in_len: 16'd84,  out_len: 16'd10};

  // Odd parity over a state word; a corrupted one-hot code shows up as even.
  function automatic logic state_parity(input logic [ST_W-1:0] st);
    state_parity = ^st;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Handshake and address/strobe bundle between the FC sequencer (master)
// and the MAC datapath / buffers (slave).
interface fc_layer_ctrl_if #(
  parameter int IN_AW  = 7,
  parameter int W_AW   = 11,
  parameter int OUT_AW = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_raddr;
  logic [W_AW-1:0]   w_raddr;
  logic              acc_clr;
  logic              acc_en;
  logic              out_wr_en;
  logic [OUT_AW-1:0] out_waddr;

  modport master (
    input  start,
    output busy, done, in_raddr, w_raddr, acc_clr, acc_en, out_wr_en, out_waddr
  );

  modport slave (
    output start,
    input  busy, done, in_raddr, w_raddr, acc_clr, acc_en, out_wr_en, out_waddr
  );
endinterface

// File: rtl/fc_dly_line.sv
// DEPTH-stage WIDTH-bit shift register with asynchronous clear; carries issue
// tags down to the point where the MAC pipeline consumes them.
module fc_dly_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift the tag one stage per clock; reset flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= {WIDTH{1'b0}};
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: sweeps feature/weight addresses,
// aligns accumulator clear/enable to the MAC pipeline and writes each neuron.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int IN_LEN  = 120,
  parameter int OUT_LEN = 10,
  parameter int IN_AW   = 7,
  parameter int OUT_AW  = 4,
  parameter int W_AW    = 11,
  parameter int CLR_DLY = 3,
  parameter int WR_DLY  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  fc_layer_ctrl_if.master  bus
);

  localparam int DR_W = $clog2(WR_DLY);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic [IN_AW-1:0]  r_in_idx;
  logic [OUT_AW-1:0] r_out_idx;
  logic [W_AW-1:0]   r_w_cnt;
  logic [DR_W-1:0]   r_drain_cnt;
  logic              r_out_wr_en;
  logic [OUT_AW-1:0] r_out_waddr;

  logic              w_run;
  logic              w_in_last;
  logic              w_out_last;
  logic              w_issue_end;
  logic              w_drain_end;
  logic              w_first;
  logic              w_last;
  logic              w_acc_en;
  logic              w_acc_clr;
  logic              w_last_dly;
  logic [OUT_AW-1:0] w_idx_dly;

  assign w_run       = (r_state == ST_RUN);
  assign w_in_last   = (r_in_idx == IN_AW'(IN_LEN - 1));
  assign w_out_last  = (r_out_idx == OUT_AW'(OUT_LEN - 1));
  assign w_issue_end = w_run & w_in_last & w_out_last;
  assign w_drain_end = (r_state == ST_DRAIN) && (r_drain_cnt == DR_W'(WR_DLY - 1));
  assign w_first     = w_run & (r_in_idx == IN_AW'(0));
  assign w_last      = w_run & w_in_last;

  // Next-state logic; start is only looked at from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start)   w_state_nxt = ST_RUN;   else w_state_nxt = ST_IDLE;
      ST_RUN:   if (w_issue_end) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_RUN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = ST_DONE;  else w_state_nxt = ST_DRAIN;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with busy/done precomputed from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Address counters; w_cnt tracks out_idx*IN_LEN + in_idx without a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_idx  <= IN_AW'(0);
      r_out_idx <= OUT_AW'(0);
      r_w_cnt   <= W_AW'(0);
    end else if (w_run) begin
      if (w_in_last) begin
        r_in_idx <= IN_AW'(0);
        if (w_out_last) begin
          r_out_idx <= OUT_AW'(0);
          r_w_cnt   <= W_AW'(0);
        end else begin
          r_out_idx <= r_out_idx + OUT_AW'(1);
          r_w_cnt   <= r_w_cnt + W_AW'(1);
        end
      end else begin
        r_in_idx <= r_in_idx + IN_AW'(1);
        r_w_cnt  <= r_w_cnt + W_AW'(1);
      end
    end else begin
      r_in_idx  <= IN_AW'(0);
      r_out_idx <= OUT_AW'(0);
      r_w_cnt   <= W_AW'(0);
    end
  end

  // Drain counter runs only while DRAIN waits for the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_drain_cnt <= DR_W'(0);
    else if (r_state == ST_DRAIN)  r_drain_cnt <= r_drain_cnt + DR_W'(1);
    else                           r_drain_cnt <= DR_W'(0);
  end

  fc_dly_line #(.DEPTH(CLR_DLY), .WIDTH(1)) u_dly_valid (
    .clk(clk), .rst_n(rst_n), .i_d(w_run),   .o_q(w_acc_en)
  );

  fc_dly_line #(.DEPTH(CLR_DLY), .WIDTH(1)) u_dly_first (
    .clk(clk), .rst_n(rst_n), .i_d(w_first), .o_q(w_acc_clr)
  );

  // Write-side lines are one stage short; the output register supplies the last stage.
  fc_dly_line #(.DEPTH(WR_DLY - 1), .WIDTH(1)) u_dly_last (
    .clk(clk), .rst_n(rst_n), .i_d(w_last),  .o_q(w_last_dly)
  );

  fc_dly_line #(.DEPTH(WR_DLY - 1), .WIDTH(OUT_AW)) u_dly_oidx (
    .clk(clk), .rst_n(rst_n), .i_d(r_out_idx), .o_q(w_idx_dly)
  );

  // Write strobe and address; the address holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr_en <= 1'b0;
      r_out_waddr <= OUT_AW'(0);
    end else begin
      r_out_wr_en <= w_last_dly;
      if (w_last_dly) r_out_waddr <= w_idx_dly;
      else            r_out_waddr <= r_out_waddr;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.in_raddr  = r_in_idx;
  assign bus.w_raddr   = r_w_cnt;
  assign bus.acc_clr   = w_acc_clr;
  assign bus.acc_en    = w_acc_en;
  assign bus.out_wr_en = r_out_wr_en;
  assign bus.out_waddr = r_out_waddr;

endmodule
